tdm_sel_mux: RTL and testbench
==============================

Name: tdm_sel_mux

Overview:
- Parametrised, registered successor to the 2:1 combinational mux (inputs x1/x2, select s, output f).
- Selects one of N channels, each W bits wide.
- Two select modes: manual (external select s) or auto-scan (channel advances every DWELL cycles).
- Sits ahead of shared display/serial logic that time-shares one datapath across several sources.

Parameters:
- N, 4, number of input channels (2..16).
- W, 1, bits per channel.
- DWELL, 2, clock cycles spent on each channel in scan mode (1..255).
- SW, clog2(N), select/channel-index width (derived, not overridden).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- x  in  N*W  packed channels; channel k at bits [k*W +: W].
- s  in  SW  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- hold  in  1  freeze all state while high.
- f  out  W  registered selected data.
- ch  out  SW  index of the channel currently driving f.
- wrap  out  1  one-cycle pulse when scan wraps from N-1 to 0.

Behaviour:
- Reset: asynchronous, active-low. While Resetn=0: f=0, ch=0, wrap=0, dwell counter=0, FSM=S_MAN. Takes effect immediately, including mid-scan. First update occurs at the first rising edge after release.
- FSM states:
  - S_MAN, S_SCAN; next state = mode, sampled each non-held edge.
  - Any state change clears the dwell counter to 0.
- Next channel (ch_nxt) by state:
  - S_MAN (or entering it): ch_nxt = s if s < N; else ch_nxt = ch (out-of-range select ignored).
  - S_SCAN (or entering it from S_MAN): ch_nxt = ch. Scan starts from the current channel with a full dwell.
  - Staying in S_SCAN: counter increments each edge. When counter == DWELL-1: counter <= 0 and ch_nxt = (ch == N-1) ? 0 : ch+1. Otherwise ch_nxt = ch.
- Register update on every non-held edge: ch <= ch_nxt; f <= x[ch_nxt].
  - Latency: one cycle. f and ch are always mutually consistent.
  - f tracks live data of the selected channel every cycle, not only at switch points.
- wrap <= 1 only on the edge where ch goes N-1 -> 0 in steady S_SCAN; otherwise 0. Never asserted in manual mode, even if s moves 3 -> 0.
- hold=1:
  - ch, f, counter and FSM keep their values; wrap <= 0.
  - hold overrides mode and s.
  - On release, the counter resumes from its frozen value.
- DWELL=1: ch advances every edge in scan mode.
- N not a power of two: ch never exceeds N-1 in either mode.

Decomposition:
- Package tdm_pkg:
  - S_MAN/S_SCAN state encoding.
  - MODE_MAN=0, MODE_SCAN=1 constants.
  - clog2 function used to derive SW.
- One sub-module: dwell_counter.
  - Parameter DWELL.
  - Inputs: Clock, Resetn, en, clr.
  - Output: tc, high when count == DWELL-1 and en=1.
  - Top level: en = ~hold, clr = state change.

Test Plan:
(Default instance N=4, W=2, DWELL=2, with x = {2'b11, 2'b10, 2'b01, 2'b00}, so f equals the channel index.)
1. Reset: drive Resetn=0 between edges mid-scan at ch=2 -> f=0, ch=0, wrap=0 immediately, without waiting for a clock edge. Release -> outputs hold until the next edge.
2. Manual select: mode=0, s=2 before edge -> after edge ch=2, f=2'b10. Then s=3 -> next edge f=2'b11. Change x channel 3 to 2'b00 -> f=2'b00 one edge later.
3. Scan wrap: mode=1 from ch=0 -> ch per edge 0,0,1,1,2,2,3,3,0. wrap=1 only in the cycle ch becomes 0; total 1 pulse per 8 cycles.
4. Hold: scan, first dwell cycle of ch=1; hold=1 for 3 edges while x toggles -> ch=1 and f frozen, wrap=0. Release -> exactly one more cycle on ch=1, then ch=2.
5. Mode switch: scan at ch=2, set mode=0, s=0 -> next edge ch=0, counter cleared. Set mode=1 -> ch stays 0 for 2 edges, then 1.
6. Non-power-of-two instance (N=3): manual s=3 -> ch unchanged. Scan -> sequence 0,0,1,1,2,2,0 with wrap on the 2 -> 0 transition.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and helpers for the time-division channel selector.
// State encoding, mode constants and the select-width function.
package tdm_pkg;

    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Counts cycles spent on one channel; tc marks the last cycle of a dwell.
// clr restarts the dwell, en freezes the count while low.
module dwell_counter #(
    parameter int DWELL = 2
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tc) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdm_sel_mux.sv
// Registered N-to-1 channel selector with manual and auto-scan modes.
// f and ch always update together, so ch names the source of f.
module tdm_sel_mux
    import tdm_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 2,
    localparam int SW   = clog2(N)
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [N*W-1:0]  x,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    input  logic            hold,
    output logic [W-1:0]    f,
    output logic [SW-1:0]   ch,
    output logic            wrap
);

    state_e        state_q, state_d;
    logic [SW-1:0] ch_q, ch_d, ch_inc;
    logic [W-1:0]  f_q;
    logic          wrap_q, wrap_d;
    logic          chg, tc, last;

    assign state_d = (mode == MODE_SCAN) ? S_SCAN : S_MAN;
    assign chg     = (state_d != state_q);
    assign last    = (ch_q == SW'(N - 1));
    assign ch_inc  = last ? '0 : ch_q + SW'(1);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (~hold),
        .clr    (chg),
        .tc     (tc)
    );

    // Entering scan keeps the current channel for a full dwell.
    always_comb begin
        ch_d   = ch_q;
        wrap_d = 1'b0;
        if (state_d == S_MAN) begin
            if (int'(s) < N) ch_d = s;
        end else if (!chg && tc) begin
            ch_d   = ch_inc;
            wrap_d = last;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_MAN;
            ch_q    <= '0;
            f_q     <= '0;
            wrap_q  <= 1'b0;
        end else if (hold) begin
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            f_q     <= x[int'(ch_d)*W +: W];
            wrap_q  <= wrap_d;
        end
    end

    assign f    = f_q;
    assign ch   = ch_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_tdm_sel_mux.sv
// Bench for tdm_sel_mux: directed scenarios plus randomized run
// against a behavioural model, on N=4, N=3 and DWELL=1 instances.
module tb_tdm_sel_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  x_a;
    logic [5:0]  x_b;
    logic [14:0] x_c;
    logic [1:0]  s_a, s_b;
    logic [2:0]  s_c;
    logic        md_a, md_b, md_c, hd_a, hd_b, hd_c;
    logic [1:0]  f_a, f_b, ch_a, ch_b;
    logic [2:0]  f_c, ch_c;
    logic        wr_a, wr_b, wr_c;

    int errors = 0;
    int checks = 0;

    int NCH[3] = '{4, 3, 5};
    int DW[3]  = '{2, 2, 1};
    int WB[3]  = '{2, 2, 3};

    int m_ch[3], m_f[3], m_dw[3];
    bit m_wr[3], m_scan[3];
    int a_f[3], a_ch[3];
    bit a_wr[3];

    localparam logic [7:0] XA = 8'b11_10_01_00;

    always #5 clk = ~clk;

    tdm_sel_mux #(.N(4), .W(2), .DWELL(2)) u_a (
        .Clock(clk), .Resetn(rst_n), .x(x_a), .s(s_a), .mode(md_a),
        .hold(hd_a), .f(f_a), .ch(ch_a), .wrap(wr_a)
    );
    tdm_sel_mux #(.N(3), .W(2), .DWELL(2)) u_b (
        .Clock(clk), .Resetn(rst_n), .x(x_b), .s(s_b), .mode(md_b),
        .hold(hd_b), .f(f_b), .ch(ch_b), .wrap(wr_b)
    );
    tdm_sel_mux #(.N(5), .W(3), .DWELL(1)) u_c (
        .Clock(clk), .Resetn(rst_n), .x(x_c), .s(s_c), .mode(md_c),
        .hold(hd_c), .f(f_c), .ch(ch_c), .wrap(wr_c)
    );

    always_comb begin
        a_f[0] = int'(f_a);  a_ch[0] = int'(ch_a); a_wr[0] = wr_a;
        a_f[1] = int'(f_b);  a_ch[1] = int'(ch_b); a_wr[1] = wr_b;
        a_f[2] = int'(f_c);  a_ch[2] = int'(ch_c); a_wr[2] = wr_c;
    end

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ch[i] = 0; m_f[i] = 0; m_dw[i] = 0;
            m_wr[i] = 0; m_scan[i] = 0;
        end
    endfunction

    // Scan: first cycle after entry starts a fresh dwell on the same channel.
    function automatic void model_step(int i, bit md, int sv, bit hd,
                                       longint unsigned xv);
        m_wr[i] = 0;
        if (hd) return;
        if (!md) begin
            m_scan[i] = 0;
            if (sv < NCH[i]) m_ch[i] = sv;
        end else if (!m_scan[i]) begin
            m_scan[i] = 1;
            m_dw[i] = 0;
        end else begin
            m_dw[i]++;
            if (m_dw[i] == DW[i]) begin
                m_dw[i] = 0;
                m_ch[i] = (m_ch[i] + 1) % NCH[i];
                m_wr[i] = (m_ch[i] == 0);
            end
        end
        m_f[i] = int'((xv >> (m_ch[i] * WB[i])) & ((64'd1 << WB[i]) - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, md_a, int'(s_a), hd_a, 64'(x_a));
        model_step(1, md_b, int'(s_b), hd_b, 64'(x_b));
        model_step(2, md_c, int'(s_c), hd_c, 64'(x_c));
        #1;
    endtask

    task automatic test_reset();
        x_a = XA; x_b = 6'b10_01_00; x_c = 15'($urandom);
        s_a = 0; s_b = 0; s_c = 0;
        md_a = 1; md_b = 0; md_c = 0;
        hd_a = 0; hd_b = 0; hd_c = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({f_a, ch_a, wr_a, ch_b, ch_c} !== '0) begin
            errors++;
            $display("FAIL rst_init got f=%0d ch=%0d wrap=%0d want 0",
                     f_a, ch_a, wr_a);
        end
        #20 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (ch_a !== 2'd2) begin
            errors++;
            $display("FAIL rst_prescan got ch=%0d want 2", ch_a);
        end
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({f_a, ch_a, wr_a} !== 5'd0) begin
            errors++;
            $display("FAIL rst_async got f=%0d ch=%0d wrap=%0d want 0",
                     f_a, ch_a, wr_a);
        end
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({f_a, ch_a, wr_a} !== 5'd0) begin
            errors++;
            $display("FAIL rst_release got f=%0d ch=%0d want 0", f_a, ch_a);
        end
    endtask

    task automatic test_manual();
        md_a = 0; s_a = 2'd2;
        tick();
        checks++;
        if (ch_a !== 2'd2 || f_a !== 2'b10) begin
            errors++;
            $display("FAIL man_s2 got ch=%0d f=%0d want 2/2", ch_a, f_a);
        end
        s_a = 2'd3;
        tick();
        checks++;
        if (ch_a !== 2'd3 || f_a !== 2'b11) begin
            errors++;
            $display("FAIL man_s3 got ch=%0d f=%0d want 3/3", ch_a, f_a);
        end
        x_a[7:6] = 2'b00;
        tick();
        checks++;
        if (f_a !== 2'b00 || wr_a !== 1'b0) begin
            errors++;
            $display("FAIL man_live got f=%0d wrap=%0d want 0/0", f_a, wr_a);
        end
        x_a = XA;
        s_a = 2'd0;
        tick();
        checks++;
        if (ch_a !== 2'd0 || wr_a !== 1'b0) begin
            errors++;
            $display("FAIL man_3to0 got ch=%0d wrap=%0d want 0/0", ch_a, wr_a);
        end
    endtask

    task automatic test_scan_wrap();
        int exp_ch[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        int pulses = 0;
        md_a = 1;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k > 0) pulses += int'(wr_a);
            checks++;
            if (int'(ch_a) !== exp_ch[k] || int'(f_a) !== exp_ch[k]
                || wr_a !== (k == 8)) begin
                errors++;
                $display("FAIL scan_e%0d got ch=%0d f=%0d wrap=%0d want %0d/%0d/%0d",
                         k, ch_a, f_a, wr_a, exp_ch[k], exp_ch[k], k == 8);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL scan_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_hold();
        tick();
        tick();
        checks++;
        if (ch_a !== 2'd1) begin
            errors++;
            $display("FAIL hold_pre got ch=%0d want 1", ch_a);
        end
        hd_a = 1;
        for (int k = 0; k < 3; k++) begin
            x_a = ~x_a;
            md_a = k[0];
            s_a = 2'd3;
            tick();
            checks++;
            if (ch_a !== 2'd1 || f_a !== 2'b01 || wr_a !== 1'b0) begin
                errors++;
                $display("FAIL hold_e%0d got ch=%0d f=%0d wrap=%0d want 1/1/0",
                         k, ch_a, f_a, wr_a);
            end
        end
        x_a = XA; md_a = 1; hd_a = 0;
        tick();
        checks++;
        if (ch_a !== 2'd1 || f_a !== 2'b01) begin
            errors++;
            $display("FAIL hold_rel1 got ch=%0d f=%0d want 1/1", ch_a, f_a);
        end
        tick();
        checks++;
        if (ch_a !== 2'd2 || f_a !== 2'b10) begin
            errors++;
            $display("FAIL hold_rel2 got ch=%0d f=%0d want 2/2", ch_a, f_a);
        end
    endtask

    task automatic test_mode_switch();
        int exp_ch[3] = '{0, 0, 1};
        md_a = 0; s_a = 2'd0;
        tick();
        checks++;
        if (ch_a !== 2'd0 || f_a !== 2'b00) begin
            errors++;
            $display("FAIL sw_man got ch=%0d f=%0d want 0/0", ch_a, f_a);
        end
        md_a = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (int'(ch_a) !== exp_ch[k]) begin
                errors++;
                $display("FAIL sw_scan_e%0d got ch=%0d want %0d",
                         k, ch_a, exp_ch[k]);
            end
        end
    endtask

    task automatic test_nonpow2();
        int exp_ch[7] = '{0, 0, 1, 1, 2, 2, 0};
        md_b = 0; s_b = 2'd2;
        tick();
        s_b = 2'd3;
        tick();
        checks++;
        if (ch_b !== 2'd2 || f_b !== 2'b10) begin
            errors++;
            $display("FAIL np2_oob got ch=%0d f=%0d want 2/2", ch_b, f_b);
        end
        s_b = 2'd0;
        tick();
        md_b = 1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (int'(ch_b) !== exp_ch[k] || wr_b !== (k == 6)) begin
                errors++;
                $display("FAIL np2_e%0d got ch=%0d wrap=%0d want %0d/%0d",
                         k, ch_b, wr_b, exp_ch[k], k == 6);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) md_a = ~md_a;
            if ($urandom_range(0, 9) == 0) md_b = ~md_b;
            if ($urandom_range(0, 9) == 0) md_c = ~md_c;
            s_a = 2'($urandom); s_b = 2'($urandom); s_c = 3'($urandom);
            hd_a = ($urandom_range(0, 5) == 0);
            hd_b = ($urandom_range(0, 5) == 0);
            hd_c = ($urandom_range(0, 5) == 0);
            x_a = 8'($urandom); x_b = 6'($urandom); x_c = 15'($urandom);
            if (k == 300) begin
                #3 rst_n = 1'b0;
                model_reset();
                #1 rst_n = 1'b1;
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (a_f[i] !== m_f[i] || a_ch[i] !== m_ch[i]
                    || a_wr[i] !== m_wr[i] || a_ch[i] >= NCH[i]) begin
                    errors++;
                    $display("FAIL rand_u%0d cyc %0d got f=%0d ch=%0d wrap=%0d want %0d/%0d/%0d",
                             i, k, a_f[i], a_ch[i], a_wr[i],
                             m_f[i], m_ch[i], m_wr[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan_wrap();
        test_hold();
        test_mode_switch();
        test_nonpow2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
